// File: rtl/resize_coord_gen.sv
// Coordinate generator for the bicubic resizer: walks target pixels in raster order and
// emits the source integer coordinate plus Q0.FRAC_W fractional offsets for each.
module resize_coord_gen #(
  parameter int COORD_W = 7,
  parameter int FRAC_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [COORD_W-1:0] H0,
  input  logic [COORD_W-1:0] V0,
  input  logic [4:0]         SW,
  input  logic [4:0]         SH,
  input  logic [5:0]         TW,
  input  logic [5:0]         TH,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic [FRAC_W-1:0]  out_row_frac,
  output logic [FRAC_W-1:0]  out_col_frac,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {S_IDLE, S_DIV_H, S_DIV_V, S_FRAC_V, S_FRAC_H, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  h0_q, h0_d;
  logic [5:0]          dh_q, dh_d, dv_q, dv_d, nv_q, nv_d;
  logic [5:0]          step_qh_q, step_qh_d, step_rh_q, step_rh_d;
  logic [5:0]          step_qv_q, step_qv_d, step_rv_q, step_rv_d;
  logic [COORD_W-1:0]  row_int_q, row_int_d, col_int_q, col_int_d;
  logic [5:0]          row_rem_q, row_rem_d, col_rem_q, col_rem_d;
  logic [5:0]          h_q, h_d, v_q, v_d;
  logic [5:0]          part_q, part_d, dvd_q, dvd_d;
  logic [FRAC_W-1:0]   quo_q, quo_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [COORD_W-1:0]  out_row_q, out_row_d, out_col_q, out_col_d;
  logic [FRAC_W-1:0]   out_row_frac_q, out_row_frac_d, out_col_frac_q, out_col_frac_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [5:0]          div_sel;
  logic                div_bit;
  logic [6:0]          step_res;
  logic [FRAC_W-1:0]   quo_new;
  logic [COORD_W+5:0]  row_nxt, col_nxt;

  // One restoring-division iteration: {quotient bit, new partial remainder}.
  function automatic logic [6:0] div_step(input logic [5:0] part, input logic bit_in,
                                          input logic [5:0] d);
    logic [6:0] sh;
    sh = {part, bit_in};
    if (sh >= {1'b0, d}) return {1'b1, 6'(sh - {1'b0, d})};
    return {1'b0, sh[5:0]};
  endfunction

  // Accumulator advance; a zero divisor never produces a carry.
  function automatic logic [COORD_W+5:0] acc_adv(input logic [COORD_W-1:0] ival,
      input logic [5:0] rem, input logic [5:0] q, input logic [5:0] r, input logic [5:0] d);
    logic [6:0] sum;
    logic       carry;
    sum   = {1'b0, rem} + {1'b0, r};
    carry = (d != 6'd0) && (sum >= {1'b0, d});
    if (carry) sum = sum - {1'b0, d};
    return {ival + COORD_W'(q) + COORD_W'(carry), sum[5:0]};
  endfunction

  assign row_nxt = acc_adv(row_int_q, row_rem_q, step_qv_q, step_rv_q, dv_q);
  assign col_nxt = acc_adv(col_int_q, col_rem_q, step_qh_q, step_rh_q, dh_q);

  always_comb begin
    state_d = state_q;       h0_d = h0_q;             dh_d = dh_q;
    dv_d = dv_q;             nv_d = nv_q;
    step_qh_d = step_qh_q;   step_rh_d = step_rh_q;
    step_qv_d = step_qv_q;   step_rv_d = step_rv_q;
    row_int_d = row_int_q;   row_rem_d = row_rem_q;
    col_int_d = col_int_q;   col_rem_d = col_rem_q;
    h_d = h_q;               v_d = v_q;
    part_d = part_q;         dvd_d = dvd_q;           quo_d = quo_q;
    cnt_d = cnt_q;
    out_valid_d = out_valid_q;        out_last_d = out_last_q;
    out_row_d = out_row_q;            out_col_d = out_col_q;
    out_row_frac_d = out_row_frac_q;  out_col_frac_d = out_col_frac_q;
    done_d = 1'b0;

    div_sel  = (state_q == S_DIV_H || state_q == S_FRAC_H) ? dh_q : dv_q;
    div_bit  = (state_q == S_DIV_H || state_q == S_DIV_V) ? dvd_q[5] : 1'b0;
    step_res = div_step(part_q, div_bit, div_sel);
    quo_new  = {quo_q[FRAC_W-2:0], step_res[6]};

    case (state_q)
      S_IDLE: if (start) begin
        h0_d = H0;            dh_d = TW - 6'd1;       dv_d = TH - 6'd1;
        nv_d = {1'b0, SH} - 6'd1;                     dvd_d = {1'b0, SW} - 6'd1;
        part_d = '0;          quo_d = '0;             cnt_d = '0;
        row_int_d = V0;       row_rem_d = '0;
        col_int_d = H0;       col_rem_d = '0;
        h_d = '0;             v_d = '0;
        state_d = S_DIV_H;
      end
      S_DIV_H, S_DIV_V: begin
        part_d = step_res[5:0];
        dvd_d  = dvd_q << 1;
        quo_d  = quo_new;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd5) begin
          quo_d = '0;
          cnt_d = '0;
          if (state_q == S_DIV_H) begin
            step_qh_d = (dh_q == 6'd0) ? 6'd0 : quo_new[5:0];
            step_rh_d = (dh_q == 6'd0) ? 6'd0 : step_res[5:0];
            part_d  = '0;
            dvd_d   = nv_q;
            state_d = S_DIV_V;
          end else begin
            step_qv_d = (dv_q == 6'd0) ? 6'd0 : quo_new[5:0];
            step_rv_d = (dv_q == 6'd0) ? 6'd0 : step_res[5:0];
            part_d  = row_rem_q;
            state_d = S_FRAC_V;
          end
        end
      end
      S_FRAC_V, S_FRAC_H: begin
        part_d = step_res[5:0];
        quo_d  = quo_new;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(FRAC_W - 1)) begin
          quo_d = '0;
          cnt_d = '0;
          if (state_q == S_FRAC_V) begin
            out_row_frac_d = (dv_q == 6'd0) ? '0 : quo_new;
            part_d  = col_rem_q;
            state_d = S_FRAC_H;
          end else begin
            out_col_frac_d = (dh_q == 6'd0) ? '0 : quo_new;
            out_row_d   = row_int_q;
            out_col_d   = col_int_q;
            out_last_d  = (h_q == dh_q) && (v_q == dv_q);
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (out_last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (h_q == dh_q) begin
          // Row change: advance the row, rewind the column to the window origin.
          h_d = '0;
          v_d = v_q + 6'd1;
          {row_int_d, row_rem_d} = row_nxt;
          col_int_d = h0_q;
          col_rem_d = '0;
          part_d    = row_nxt[5:0];
          state_d   = S_FRAC_V;
        end else begin
          h_d = h_q + 6'd1;
          {col_int_d, col_rem_d} = col_nxt;
          part_d  = col_nxt[5:0];
          state_d = S_FRAC_H;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;     h0_q <= '0;         dh_q <= '0;
      dv_q <= '0;            nv_q <= '0;
      step_qh_q <= '0;       step_rh_q <= '0;    step_qv_q <= '0;    step_rv_q <= '0;
      row_int_q <= '0;       row_rem_q <= '0;    col_int_q <= '0;    col_rem_q <= '0;
      h_q <= '0;             v_q <= '0;
      part_q <= '0;          dvd_q <= '0;        quo_q <= '0;        cnt_q <= '0;
      out_valid_q <= 1'b0;   out_last_q <= 1'b0; out_row_q <= '0;    out_col_q <= '0;
      out_row_frac_q <= '0;  out_col_frac_q <= '0;
      busy_q <= 1'b0;        done_q <= 1'b0;
    end else begin
      state_q <= state_d;    h0_q <= h0_d;       dh_q <= dh_d;
      dv_q <= dv_d;          nv_q <= nv_d;
      step_qh_q <= step_qh_d; step_rh_q <= step_rh_d;
      step_qv_q <= step_qv_d; step_rv_q <= step_rv_d;
      row_int_q <= row_int_d; row_rem_q <= row_rem_d;
      col_int_q <= col_int_d; col_rem_q <= col_rem_d;
      h_q <= h_d;            v_q <= v_d;
      part_q <= part_d;      dvd_q <= dvd_d;     quo_q <= quo_d;     cnt_q <= cnt_d;
      out_valid_q <= out_valid_d; out_last_q <= out_last_d;
      out_row_q <= out_row_d; out_col_q <= out_col_d;
      out_row_frac_q <= out_row_frac_d; out_col_frac_q <= out_col_frac_d;
      busy_q <= busy_d;      done_q <= done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign out_row_frac = out_row_frac_q;
  assign out_col_frac = out_col_frac_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_resize_coord_gen.sv
// Bench for resize_coord_gen: random and directed frames against a closed-form mapping model.
module tb_resize_coord_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [6:0] H0 = '0, V0 = '0;
  logic [4:0] SW = '0, SH = '0;
  logic [5:0] TW = '0, TH = '0;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, busy, done;
  logic [6:0] out_row, out_col;
  logic [7:0] out_row_frac, out_col_frac;

  int errors = 0;
  int checks = 0;
  int f_h0, f_v0, f_sw, f_sh, f_tw, f_th;
  logic [30:0] got_q[$];

  resize_coord_gen #(.COORD_W(7), .FRAC_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .H0(H0), .V0(V0), .SW(SW), .SH(SH),
    .TW(TW), .TH(TH), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_row_frac(out_row_frac),
    .out_col_frac(out_col_frac), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] pack(input int r, input int c, input int rf, input int cf,
                                       input int l);
    return {7'(r), 7'(c), 8'(rf), 8'(cf), 1'(l)};
  endfunction

  // pos(t) = origin + t*(S-1)/(T-1), split into integer part and floor(256 * remainder / d).
  function automatic logic [30:0] model(input int idx);
    int th, tv, dh, nh, dv, nv, r, c, rf, cf;
    th = idx % f_tw;  tv = idx / f_tw;
    dh = f_tw - 1;    nh = f_sw - 1;
    dv = f_th - 1;    nv = f_sh - 1;
    if (dh == 0) begin c = f_h0; cf = 0; end
    else begin c = f_h0 + (th * nh) / dh; cf = ((th * nh) % dh) * 256 / dh; end
    if (dv == 0) begin r = f_v0; rf = 0; end
    else begin r = f_v0 + (tv * nv) / dv; rf = ((tv * nv) % dv) * 256 / dv; end
    return pack(r % 128, c % 128, rf, cf, (idx == f_tw * f_th - 1) ? 1 : 0);
  endfunction

  task automatic run_frame(input int h0, input int v0, input int sw, input int sh,
                           input int tw, input int th, input bit rand_rdy, input int abort_at);
    int total, idx, n, dones;
    bit pv, pr, phs, rdy, finished;
    logic [30:0] prev, cur;
    f_h0 = h0; f_v0 = v0; f_sw = sw; f_sh = sh; f_tw = tw; f_th = th;
    total = tw * th; idx = 0; dones = 0;
    pv = 0; pr = 0; phs = 0; finished = 0; prev = '0;
    got_q.delete();
    H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    // Scramble the configuration; the DUT must use the values captured at start.
    H0 = 7'($urandom); V0 = 7'($urandom); SW = 5'($urandom); SH = 5'($urandom);
    TW = 6'($urandom); TH = 6'($urandom);
    for (n = 1; n < 40; n++) begin
      @(posedge CLK); #1;
      if (out_valid) break;
    end
    chk("first_latency", n, 28);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      cur = {out_row, out_col, out_row_frac, out_col_frac, out_last};
      if (done) dones++;
      if (pv && !pr) begin
        chk("stall_hold", cur, prev);
        chk("stall_valid", out_valid, 1);
      end
      if (phs) chk("valid_drop", out_valid, 0);
      if (idx == total) begin
        chk("done_after_last", done, 1);
        finished = 1;
        break;
      end
      rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
      out_ready = rdy;
      phs = out_valid && rdy;
      if (phs) begin
        chk("tuple", cur, model(idx));
        got_q.push_back(cur);
        idx++;
      end
      pv = out_valid; pr = rdy; prev = cur;
      if (abort_at > 0 && idx == abort_at) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        out_ready = 1'b1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        dones = 0;
        repeat (40) begin
          if (done || out_valid || busy) dones++;
          @(posedge CLK); #1;
        end
        chk("abort_quiet", dones, 0);
        return;
      end
      @(posedge CLK); #1;
    end
    chk("tuple_count", idx, total);
    chk("frame_finished", finished, 1);
    @(posedge CLK); #1;
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_count", dones, 1);
    out_ready = 1'b1;
  endtask

  initial begin
    int sw, sh, tw, th;
    // Reset with start held high: must stay idle with every output at zero.
    RST = 1'b1; start = 1'b1; H0 = 7'd10; V0 = 7'd10; SW = 5'd4; SH = 5'd4;
    TW = 6'd3; TH = 6'd3;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_outputs", {out_valid, out_row, out_col, out_row_frac, out_col_frac, out_last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 1'b0; RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);

    // Reference frame, always ready.
    run_frame(81, 18, 17, 15, 22, 28, 1'b0, 0);
    chk("ref_size", got_q.size(), 616);
    chk("ref_t0", got_q[0], pack(18, 81, 0, 0, 0));
    chk("ref_t1", got_q[1], pack(18, 81, 0, 195, 0));
    chk("ref_t2", got_q[2], pack(18, 82, 0, 134, 0));
    chk("ref_row1", got_q[22], pack(18, 81, 132, 0, 0));
    chk("ref_last", got_q[615], pack(32, 97, 0, 0, 1));

    // Same frame under random backpressure.
    run_frame(81, 18, 17, 15, 22, 28, 1'b1, 0);
    chk("bp_size", got_q.size(), 616);

    // Single-pixel target.
    run_frame(3, 4, 5, 5, 1, 1, 1'b0, 0);
    chk("one_px", got_q[0], pack(4, 3, 0, 0, 1));

    // Integer step greater than zero.
    run_frame(0, 5, 31, 3, 4, 2, 1'b0, 0);
    chk("down_c1", got_q[1], pack(5, 10, 0, 0, 0));
    chk("down_c3", got_q[3], pack(5, 30, 0, 0, 0));
    chk("down_r1", got_q[7], pack(7, 30, 0, 0, 1));

    // Abort at tuple 50, then a clean rerun.
    run_frame(81, 18, 17, 15, 22, 28, 1'b0, 50);
    run_frame(81, 18, 17, 15, 22, 28, 1'b0, 0);
    chk("rerun_t0", got_q[0], pack(18, 81, 0, 0, 0));
    chk("rerun_size", got_q.size(), 616);

    // Small random frames within the legal window.
    for (int k = 0; k < 6; k++) begin
      sw = 1 + int'($urandom % 31);
      sh = 1 + int'($urandom % 31);
      tw = 1 + int'($urandom % 8);
      th = 1 + int'($urandom % 6);
      run_frame(int'($urandom % (101 - sw)), int'($urandom % (101 - sh)), sw, sh, tw, th,
                1'($urandom % 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/resize_coord_gen.md
Name: resize_coord_gen

Overview:
- Upstream stage of the bicubic image resizer.
- For every target pixel, in raster order, it produces the source-image integer coordinate (row, col) and the Q0.8 fractional offsets (row_frac, col_frac).
- The interpolation datapath consumes these to address the 100x100 image ROM and to drive the cubic engine's x input.
- Mapping per axis: pos(t) = origin + t*(S-1)/(T-1), for t = 0..T-1.

Parameters:
COORD_W, 7, width of integer source coordinates and origins
FRAC_W, 8, width of fractional outputs (Q0.FRAC_W); also the number of fraction-division iterations

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
H0  in  7  source column origin
V0  in  7  source row origin
SW  in  5  source window width
SH  in  5  source window height
TW  in  6  target width, >=1
TH  in  6  target height, >=1
out_valid  out  1  coordinate tuple valid
out_ready  in  1  downstream accepts tuple
out_row  out  7  integer source row
out_col  out  7  integer source column
out_row_frac  out  8  row fraction, Q0.8
out_col_frac  out  8  column fraction, Q0.8
out_last  out  1  tuple is the final target pixel (TH-1, TW-1)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last tuple is accepted

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST).
- On reset: state IDLE; all outputs 0; all internal counters and accumulators 0.
- Reset asserted mid-operation aborts the frame; no done pulse is produced.
- Inputs H0..TH are latched on the start cycle. Later changes have no effect until the next start.
- Per-axis step: dh = TW-1, nh = SW-1 (likewise dv = TH-1, nv = SH-1).
  - Compute step_q = nh/dh and step_r = nh%dh with a 6-iteration restoring divider, one bit per cycle.
  - If dh==0: step_q = 0, step_r = 0, and every fraction on that axis is 0.
- State machine:
  - IDLE: start -> DIV_H.
  - DIV_H: 6 cycles -> DIV_V.
  - DIV_V: 6 cycles -> FRAC_V.
  - FRAC_V: 8 cycles -> FRAC_H.
  - FRAC_H: 8 cycles -> OUT.
  - OUT: out_valid=1.
    - On out_valid && out_ready with the last tuple -> IDLE; done=1 on the following cycle.
    - Else if col index wraps (h==TW-1): h=0, v++, row accumulator advances, col accumulator resets to (H0, rem 0) -> FRAC_V.
    - Else: h++, col accumulator advances -> FRAC_H.
- Accumulator advance (each axis): rem += step_r; if rem >= d then rem -= d and carry=1; int += step_q + carry. rem is always < d.
- Fraction: frac = floor(rem*256/d), computed by 8-iteration restoring division of rem<<8 by d. The result is never >255 because rem < d.
- Outputs:
  - out_* are registered and held stable while out_valid && !out_ready.
  - out_valid deasserts the cycle after handshake.
  - Minimum throughput: 9 cycles per tuple; 17 cycles on a row change.
- Latency: first out_valid occurs 28 cycles after the start cycle (6+6+8+8).
- start while busy is ignored.
- A start in the same cycle as done is accepted, because the state is already IDLE.
- Integer widths: the caller guarantees origin+S-1 <= 99. No clamping is performed; arithmetic wraps modulo 128.

Test Plan:
1. Reset then idle: RST for 2 cycles -> all outputs 0, busy=0; start with RST high is ignored.
2. Reference frame: H0=81 V0=18 SW=17 SH=15 TW=22 TH=28, out_ready=1.
   - First tuple at cycle +28: row=18 col=81 frac 0/0.
   - 2nd tuple: col=81 col_frac=195.
   - 3rd tuple: col=82 col_frac=134.
   - First tuple of row 1: row=18 row_frac=132.
   - Last tuple: row=32 col=97 fracs 0, out_last=1.
   - Totals: 616 tuples, one done pulse.
3. Backpressure: same frame with out_ready toggling randomly -> outputs stable while stalled; tuple sequence identical to scenario 2; no tuple lost or duplicated.
4. Degenerate size: TW=1 TH=1 SW=5 SH=5 H0=3 V0=4 -> exactly one tuple (row=4 col=3 fracs 0, out_last=1), then done.
5. Downscale with step_q>0: H0=0 SW=31 TW=4 -> cols 0,10,20,30 with col_frac all 0.
6. Reset mid-frame at tuple 50 of scenario 2 -> next cycle IDLE, out_valid=0, no done. A new start reproduces scenario 2 from its first tuple.
